// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: resolves branch/JAL from decode,
// drives the fetch handshake, redirects the PC and flushes IF/ID.
module pc_sequencer #(
  parameter int unsigned XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            id_valid,
  input  logic            branch,
  input  logic            jump,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            if_ack,
  output logic            if_req,
  output logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] pc,
  output logic            flush,
  output logic            redirect,
  output logic            misalign
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] STEP = XLEN'(4);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_t state;
  state_t state_nx;
  logic [2:0] cnt;
  logic [2:0] cnt_nx;

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_nx;
  logic cond;
  logic taken;
  logic take;
  logic mis;
  logic req_nx;
  logic flush_nx;
  logic redir_nx;
  logic mis_nx;

  assign sum    = id_pc + imm;
  assign target = {sum[XLEN-1:1], 1'b0};

  // branch condition from func3
  always_comb begin
    cond = 1'b0;
    case (func3)
      3'b000:  cond = (rs1_data == rs2_data);
      3'b001:  cond = (rs1_data != rs2_data);
      3'b100:  cond = ($signed(rs1_data) < $signed(rs2_data));
      3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  cond = (rs1_data < rs2_data);
      3'b111:  cond = (rs1_data >= rs2_data);
      default: cond = 1'b0;
    endcase
  end

  // a jump wins over a branch; misaligned targets never redirect
  assign taken = id_valid & ~stall & (state == FETCH)
               & (jump | (branch & cond));
  assign take  = taken & ~target[1];
  assign mis   = taken & target[1];

  // state and flush counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // next-state logic; flush count runs even under stall
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      BOOT: state_nx = FETCH;
      FETCH: begin
        if (take) begin
          state_nx = FLUSH;
          cnt_nx   = FLUSH_INIT;
        end
      end
      FLUSH: begin
        cnt_nx = cnt - 3'd1;
        if (cnt <= 3'd1) begin
          state_nx = FETCH;
          cnt_nx   = 3'd0;
        end
      end
      default: begin
        state_nx = BOOT;
        cnt_nx   = 3'd0;
      end
    endcase
  end

  // next values of the registered outputs and PC
  always_comb begin
    pc_nx    = pc;
    req_nx   = (state_nx != BOOT);
    flush_nx = (state_nx == FLUSH);
    redir_nx = take;
    mis_nx   = mis;
    if (take) begin
      pc_nx = target;
    end else if (state != BOOT && !stall && if_ack) begin
      pc_nx = pc + STEP;
    end
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      if_req   <= 1'b0;
      flush    <= 1'b0;
      redirect <= 1'b0;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_nx;
      if_req   <= req_nx;
      flush    <= flush_nx;
      redirect <= redir_nx;
      misalign <= mis_nx;
    end
  end

  assign if_addr = pc;

endmodule
